// File: rtl/yildiz_mem_pkg.sv
// -----------------------------------------------------------------------------
// yildiz_mem_pkg
// Shared constants and types for the data-RAM arbiter slice.
// -----------------------------------------------------------------------------
package yildiz_mem_pkg;

    // RAM geometry: 4096 x 16-bit words
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 12;

    // Arbiter sequencer states
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Requester port indices
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // One-hot mask for a port index, used to exclude the port being served
    function automatic logic [1:0] port_mask(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
// Combinational two-way picker. Ports flagged in excl are ignored. When both
// remaining requesters are eligible, the one that was not served last wins.
// -----------------------------------------------------------------------------
module arb_pick2
    import yildiz_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] excl,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    logic [1:0] elig;

    assign elig = req & ~excl;

    // Choose a winner among the eligible requesters
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (latch).
        winner = PORT_FETCH;
        valid  = |elig;
        case (elig)
            2'b01:   winner = PORT_FETCH;
            2'b10:   winner = PORT_LSU;
            2'b11:   winner = ~last;
            default: winner = PORT_FETCH;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Two-port arbiter and sequencer in front of the single-port data RAM
// (asynchronous read, synchronous write). Port 0 is instruction fetch, port 1
// is load/store. Each winning command is latched, drives the RAM for exactly
// one ACCESS cycle, and reads return registered data with an rvalid pulse.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection on
// simultaneous requests in IDLE; otherwise port 0 has fixed priority there.
// -----------------------------------------------------------------------------
module ram_arbiter
    import yildiz_mem_pkg::*;
#(
    parameter int DATA_WIDTH = yildiz_mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = yildiz_mem_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,

    output logic                  busy
);

    arb_state_t            state;
    arb_state_t            state_nx;

    // Command register: the command currently owning the RAM (or the last one)
    logic                  cmd_port;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic [1:0]            excl;
    logic                  last;
    logic                  pick_port;
    logic                  pick_valid;
    logic                  cmd_load;
    logic                  rd_done;

    // While a command is executing its requester still holds req high for the
    // consumed command, so that port must not be picked again this cycle.
    assign excl = (state == ACCESS) ? port_mask(cmd_port) : 2'b00;

    arb_pick2 u_pick (
        .req    ({req1, req0}),
        .excl   (excl),
        .last   (last),
        .winner (pick_port),
        .valid  (pick_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer: remembers which port was granted most recently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PORT_LSU;
        end else if (state == ACCESS) begin
            last <= cmd_port;
        end
    end
`else
    // Fixed priority: pretending port 1 was always served last makes fetch win
    assign last = PORT_LSU;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, command load and state-decoded RAM/grant controls
    always_comb begin
        state_nx = state;
        cmd_load = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_we   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    cmd_load = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                busy   = 1'b1;
                ram_we = cmd_we;
                gnt0   = (cmd_port == PORT_FETCH);
                gnt1   = (cmd_port == PORT_LSU);
                // Back-to-back only when the other port is waiting
                if (pick_valid) begin
                    cmd_load = 1'b1;
                    state_nx = ACCESS;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // RAM address and write data come straight from the command register, so
    // they hold the last command outside ACCESS
    assign ram_addr = cmd_addr;
    assign ram_din  = cmd_wdata;

    // Latch the winning requester's command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_port  <= PORT_FETCH;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (cmd_load) begin
            cmd_port <= pick_port;
            if (pick_port == PORT_LSU) begin
                cmd_we    <= we1;
                cmd_addr  <= addr1;
                cmd_wdata <= wdata1;
            end else begin
                cmd_we    <= we0;
                cmd_addr  <= addr0;
                cmd_wdata <= wdata0;
            end
        end
    end

    // A read finishes at the edge that ends its ACCESS cycle
    assign rd_done = (state == ACCESS) && !cmd_we;

    // Capture read data for the served port and pulse its rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd_done && (cmd_port == PORT_FETCH);
            rvalid1 <= rd_done && (cmd_port == PORT_LSU);
            if (rd_done && (cmd_port == PORT_FETCH)) begin
                rdata0 <= ram_dout;
            end
            if (rd_done && (cmd_port == PORT_LSU)) begin
                rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the single-port 16-bit data RAM (asynchronous read, synchronous write, 4096 words). It lets two requesters share the RAM: port 0 is the CPU instruction fetch and port 1 is the CPU load/store or loader path. It latches each winning command, drives the RAM for exactly one cycle, and returns registered read data with a valid pulse. It sits between the CPU core and the RAM instance.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 12, RAM address width (depth = 1<<ADDR_WIDTH)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0 / req1  input  1  request; held high with a stable command until gnt seen
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_WIDTH  word address
- wdata0 / wdata1  input  DATA_WIDTH  write data
- gnt0 / gnt1  output  1  one-cycle pulse: command is being executed this cycle
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdataN holds this port's read result
- rdata0 / rdata1  output  DATA_WIDTH  registered read data; holds until the port's next read
- ram_we  output  1  to RAM write enable
- ram_addr  output  ADDR_WIDTH  to RAM address
- ram_din  output  DATA_WIDTH  to RAM write data
- ram_dout  input  DATA_WIDTH  from RAM asynchronous read data
- busy  output  1  high while state is ACCESS

## Operation
- FSM has two states: IDLE and ACCESS. Command register holds cmd_port, cmd_we, cmd_addr and cmd_wdata.
- IDLE: if any req is high, pick a winner, latch its command, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: ram_addr = cmd_addr and ram_din = cmd_wdata. ram_we = cmd_we. gnt[cmd_port] = 1.
  - At the cycle end, a read captures ram_dout into rdata[cmd_port], and rvalid[cmd_port] pulses next cycle.
  - Next-state arbitration excludes cmd_port, because its req is still high for the consumed command.
  - If the other port requests, latch it and stay in ACCESS (back-to-back). Otherwise go to IDLE.
- Throughput limits:
  - Alternating ports: 1 access per cycle.
  - A single port: 1 access per 2 cycles.
- Winner selection when both ports request in IDLE follows the Configuration section.
- Outside ACCESS:
  - ram_we = 0 and no gnt is asserted.
  - ram_addr and ram_din hold the last command register values.
- Writes never produce rvalid.
- A write followed by a read of the same address returns the new data. The RAM write commits at the edge ending the write's ACCESS cycle.
- Reset values: state IDLE, all gnt = 0, all rvalid = 0, ram_we = 0, busy = 0, ram_addr = 0, ram_din = 0, rdata0 = rdata1 = 0, round-robin pointer = last-served port 1.
- Reset asserted mid-ACCESS:
  - ram_we, gnt and busy drop immediately, asynchronously, because they are decoded from the state register.
  - The pending command is dropped. No write occurs and no rvalid is produced.
  - The requester re-issues its command after reset.

## Timing
- Edge k samples req high in IDLE. The cycle after edge k has gnt high and the RAM driven. The cycle after edge k+1 has rvalid high with rdata valid.
- Read latency is 2 cycles from first sampled req to rvalid, and 1 cycle from gnt to rvalid.
- A requester may change req or command in the cycle after it samples gnt = 1.
- gnt and rvalid are never high on both ports in the same cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests in IDLE go to the port not served last.
  - The pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: port 0 always wins in IDLE.
  - The pointer logic is absent.
  - Back-to-back alternation in ACCESS is unchanged.

## Structure
- Shared package yildiz_mem_pkg:
  - Constants: DATA_WIDTH = 16, ADDR_WIDTH = 12.
  - State typedef: IDLE, ACCESS.
  - Port-index constants: PORT_FETCH = 0, PORT_LSU = 1.
- One sub-module, arb_pick2: a combinational 2-way picker taking req vector, exclude mask and last-served pointer, producing a winner index and a valid flag.
- The top module holds the FSM, the command register and the rdata/rvalid registers.

## Test plan
- Reset sequence:
  - Stimulus: rst_n low for 3 cycles, then high with no req.
  - Required: all outputs 0, busy = 0, ram_we never asserted.
- Single read:
  - Stimulus: preload RAM[0x010] = 0xBEEF; req1 reads 0x010.
  - Required: gnt1 one cycle after req is sampled; rvalid1 with rdata1 = 0xBEEF the next cycle.
- Write-then-read:
  - Stimulus: port 0 writes 0x5A5A to 0x123, then port 1 reads 0x123 back-to-back.
  - Required: gnt0 then gnt1 in consecutive cycles; rdata1 = 0x5A5A.
- Contention:
  - Stimulus: both ports hold reads continuously for 6 grants.
  - Required with ARB_ROUND_ROBIN_EN: grant order 0,1,0,1,0,1.
  - Required without it: port 0 first, then alternating 1 access/cycle, gnt never on both ports at once.
- Single-port streaming:
  - Stimulus: port 0 issues 4 reads to 0x000–0x003.
  - Required: gnt0 every other cycle; busy toggles; 4 rvalid0 pulses with correct data.
- Reset mid-write:
  - Stimulus: rst_n low during the ACCESS cycle of a write of 0xFFFF to 0x0AA.
  - Required: ram_we falls immediately; RAM[0x0AA] keeps its old value; no gnt after reset until a new req is sampled.
